// File: rtl/count_job_sequencer.sv
// count_job_sequencer: queues count jobs in a FIFO and runs each one through an FSM counter's start/N/done handshake.
// Optional watchdog on the WAIT state is enabled by defining SEQ_TIMEOUT_EN.
module count_job_sequencer #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  input  logic [WIDTH-1:0]         job_n,
  output logic                     job_ready,
  output logic                     ctr_start,
  output logic [WIDTH-1:0]         ctr_n,
  input  logic                     ctr_done,
  output logic                     cmpl_valid,
  output logic [WIDTH-1:0]         cmpl_n,
  output logic                     cmpl_err,
  output logic                     err_timeout,
  output logic [31:0]              jobs_done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic [1:0]               state_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, COMPLETE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [WIDTH-1:0] ctr_n_q, ctr_n_d, cmpl_n_q, cmpl_n_d, head;
  logic [31:0] jobs_q, jobs_d;
  logic ctr_done_q, pend_q, pend_d, abort_q, abort_d, err_q, err_d;
  logic push, pop, done_evt, expire;
  assign job_ready = level_q != LW'(DEPTH);
  assign push      = job_valid && job_ready;
  assign pop       = state_q == IDLE && level_q != '0 && !ctr_done;
  assign head      = mem_q[rd_ptr_q];
  assign done_evt  = ctr_done && !ctr_done_q;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  assign expire = state_q == WAIT && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    tmr_q <= (rst || state_q != WAIT) ? '0 : tmr_q + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    ctr_n_d  = ctr_n_q;
    cmpl_n_d = cmpl_n_q;
    pend_d   = 1'b0;
    abort_d  = abort_q;
    err_d    = err_q;
    jobs_d   = jobs_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    case (state_q)
      IDLE: if (pop) begin
        ctr_n_d  = head;
        cmpl_n_d = head;
        abort_d  = 1'b0;
        state_d  = head == '0 ? COMPLETE : ISSUE;
      end
      // A done edge arriving alongside the start pulse is remembered for WAIT
      ISSUE: begin
        pend_d  = done_evt;
        state_d = WAIT;
      end
      WAIT: if (done_evt || pend_q) state_d = COMPLETE;
      else if (expire) begin
        state_d = COMPLETE;
        abort_d = 1'b1;
        err_d   = 1'b1;
      end
      COMPLETE: begin
        jobs_d  = jobs_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ctr_n_q    <= '0;
      cmpl_n_q   <= '0;
      jobs_q     <= '0;
      ctr_done_q <= 1'b0;
      pend_q     <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ctr_n_q    <= ctr_n_d;
      cmpl_n_q   <= cmpl_n_d;
      jobs_q     <= jobs_d;
      ctr_done_q <= ctr_done;
      pend_q     <= pend_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= job_n;
  assign ctr_start   = state_q == ISSUE;
  assign ctr_n       = ctr_n_q;
  assign cmpl_valid  = state_q == COMPLETE;
  assign cmpl_n      = cmpl_n_q;
  assign cmpl_err    = state_q == COMPLETE && abort_q;
  assign err_timeout = err_q;
  assign jobs_done   = jobs_q;
  assign fifo_level  = level_q;
  assign busy        = state_q != IDLE || level_q != '0;
  assign state_out   = state_q;
endmodule
